// File: rtl/naive_bus_arbiter2.sv
// naive_bus_arbiter2 -- two-master to one-slave naive-bus arbiter.
//   Purpose : lets m0 (CPU data port) and m1 (UART ISP/debug master) share one
//             naive-bus slave. Ownership is held for exactly one transaction and
//             read data is routed back to the master whose read was granted.
//   Latency : one cycle of arbitration (IDLE -> OWNx), then requests and grants
//             pass combinationally; one IDLE cycle between transactions.
//   Backpressure : the slave's rd_gnt/wr_gnt pass straight to the owner; the
//             non-owner sees no grant and simply keeps requesting.
//   Config  : define NAIVE_ARB_FIXED_PRIO_EN for fixed priority (m0 always wins a
//             tie); otherwise round-robin on the last completed grant.
//   Ports   : clk, rst_n (async, active-low)
//             m0_* / m1_*  master-side naive bus (req/addr/be/data in, gnt/rd_data out)
//             s_*          slave-side naive bus (req/addr/be/data out, gnt/rd_data in)
//             o_owner      one-hot owner: 01 = m0, 10 = m1, 00 = idle
module naive_bus_arbiter2 (
   input  logic        clk,
   input  logic        rst_n,
   // master 0 (CPU data port)
   input  logic        m0_rd_req_i,
   input  logic [31:0] m0_rd_addr_i,
   input  logic [3:0]  m0_rd_be_i,
   output logic        m0_rd_gnt_o,
   output logic [31:0] m0_rd_data_o,
   input  logic        m0_wr_req_i,
   input  logic [31:0] m0_wr_addr_i,
   input  logic [31:0] m0_wr_data_i,
   input  logic [3:0]  m0_wr_be_i,
   output logic        m0_wr_gnt_o,
   // master 1 (UART ISP/debug)
   input  logic        m1_rd_req_i,
   input  logic [31:0] m1_rd_addr_i,
   input  logic [3:0]  m1_rd_be_i,
   output logic        m1_rd_gnt_o,
   output logic [31:0] m1_rd_data_o,
   input  logic        m1_wr_req_i,
   input  logic [31:0] m1_wr_addr_i,
   input  logic [31:0] m1_wr_data_i,
   input  logic [3:0]  m1_wr_be_i,
   output logic        m1_wr_gnt_o,
   // shared slave
   output logic        s_rd_req_o,
   output logic [31:0] s_rd_addr_o,
   output logic [3:0]  s_rd_be_o,
   input  logic        s_rd_gnt_i,
   input  logic [31:0] s_rd_data_i,
   output logic        s_wr_req_o,
   output logic [31:0] s_wr_addr_o,
   output logic [31:0] s_wr_data_o,
   output logic [3:0]  s_wr_be_o,
   input  logic        s_wr_gnt_i,
   // current owner
   output logic [1:0]  o_owner
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   rd_owner_q, rd_owner_d;   // master that owns the in-flight read data
   logic   req0, req1;
   logic   rd_done, txn_done;
   logic   tie_pick_m1;              // who wins when both request in IDLE

   assign req0 = m0_rd_req_i | m0_wr_req_i;
   assign req1 = m1_rd_req_i | m1_wr_req_i;

   // s_*_req_o are zero in IDLE, so these can only fire inside an ownership.
   assign rd_done  = s_rd_req_o & s_rd_gnt_i;
   assign txn_done = rd_done | (s_wr_req_o & s_wr_gnt_i);

`ifdef NAIVE_ARB_FIXED_PRIO_EN
   assign tie_pick_m1 = 1'b0;
`else
   logic last_grant_q, last_grant_d;

   // Only a completed transaction updates last_grant; an abandoned ownership
   // (owner dropped its request) leaves it alone.
   always_comb begin
      last_grant_d = last_grant_q;
      if (txn_done) begin
         if (state_q == ST_OWN0) last_grant_d = 1'b0;
         else if (state_q == ST_OWN1) last_grant_d = 1'b1;
      end
   end

   // Reset to 1 so that m0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= 1'b1;
      else        last_grant_q <= last_grant_d;
   end

   assign tie_pick_m1 = ~last_grant_q;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rd_owner_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      rd_owner_d = rd_owner_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 && req1) state_d = tie_pick_m1 ? ST_OWN1 : ST_OWN0;
            else if (req0)    state_d = ST_OWN0;
            else if (req1)    state_d = ST_OWN1;
         end
         ST_OWN0: begin
            if (rd_done) rd_owner_d = 1'b0;
            if (txn_done || !req0) state_d = ST_IDLE;
         end
         ST_OWN1: begin
            if (rd_done) rd_owner_d = 1'b1;
            if (txn_done || !req1) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: steer the owner onto the slave, grants back to the owner.
   always_comb begin
      s_rd_req_o  = 1'b0;
      s_rd_addr_o = 32'h0;
      s_rd_be_o   = 4'h0;
      s_wr_req_o  = 1'b0;
      s_wr_addr_o = 32'h0;
      s_wr_data_o = 32'h0;
      s_wr_be_o   = 4'h0;
      m0_rd_gnt_o = 1'b0;
      m0_wr_gnt_o = 1'b0;
      m1_rd_gnt_o = 1'b0;
      m1_wr_gnt_o = 1'b0;
      o_owner     = 2'b00;
      case (state_q)
         ST_OWN0: begin
            s_rd_req_o  = m0_rd_req_i;
            s_rd_addr_o = m0_rd_addr_i;
            s_rd_be_o   = m0_rd_be_i;
            s_wr_req_o  = m0_wr_req_i;
            s_wr_addr_o = m0_wr_addr_i;
            s_wr_data_o = m0_wr_data_i;
            s_wr_be_o   = m0_wr_be_i;
            m0_rd_gnt_o = s_rd_gnt_i;
            m0_wr_gnt_o = s_wr_gnt_i;
            o_owner     = 2'b01;
         end
         ST_OWN1: begin
            s_rd_req_o  = m1_rd_req_i;
            s_rd_addr_o = m1_rd_addr_i;
            s_rd_be_o   = m1_rd_be_i;
            s_wr_req_o  = m1_wr_req_i;
            s_wr_addr_o = m1_wr_addr_i;
            s_wr_data_o = m1_wr_data_i;
            s_wr_be_o   = m1_wr_be_i;
            m1_rd_gnt_o = s_rd_gnt_i;
            m1_wr_gnt_o = s_wr_gnt_i;
            o_owner     = 2'b10;
         end
         default: ;
      endcase
   end

   // Read data follows rd_owner, not the current state, so data returning one
   // cycle after a grant reaches the right master even if ownership moved on.
   assign m0_rd_data_o = rd_owner_q ? 32'h0 : s_rd_data_i;
   assign m1_rd_data_o = rd_owner_q ? s_rd_data_i : 32'h0;

endmodule

// File: tb/tb_naive_bus_arbiter2.sv
module tb_naive_bus_arbiter2;

   logic        clk;
   logic        rst_n;
   logic        m0_rd_req, m0_rd_gnt, m0_wr_req, m0_wr_gnt;
   logic [31:0] m0_rd_addr, m0_rd_data, m0_wr_addr, m0_wr_data;
   logic [3:0]  m0_rd_be, m0_wr_be;
   logic        m1_rd_req, m1_rd_gnt, m1_wr_req, m1_wr_gnt;
   logic [31:0] m1_rd_addr, m1_rd_data, m1_wr_addr, m1_wr_data;
   logic [3:0]  m1_rd_be, m1_wr_be;
   logic        s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
   logic [31:0] s_rd_addr, s_rd_data, s_wr_addr, s_wr_data;
   logic [3:0]  s_rd_be, s_wr_be;
   logic [1:0]  o_owner;

   naive_bus_arbiter2 dut (
      .clk(clk), .rst_n(rst_n),
      .m0_rd_req_i(m0_rd_req), .m0_rd_addr_i(m0_rd_addr), .m0_rd_be_i(m0_rd_be),
      .m0_rd_gnt_o(m0_rd_gnt), .m0_rd_data_o(m0_rd_data),
      .m0_wr_req_i(m0_wr_req), .m0_wr_addr_i(m0_wr_addr), .m0_wr_data_i(m0_wr_data),
      .m0_wr_be_i(m0_wr_be), .m0_wr_gnt_o(m0_wr_gnt),
      .m1_rd_req_i(m1_rd_req), .m1_rd_addr_i(m1_rd_addr), .m1_rd_be_i(m1_rd_be),
      .m1_rd_gnt_o(m1_rd_gnt), .m1_rd_data_o(m1_rd_data),
      .m1_wr_req_i(m1_wr_req), .m1_wr_addr_i(m1_wr_addr), .m1_wr_data_i(m1_wr_data),
      .m1_wr_be_i(m1_wr_be), .m1_wr_gnt_o(m1_wr_gnt),
      .s_rd_req_o(s_rd_req), .s_rd_addr_o(s_rd_addr), .s_rd_be_o(s_rd_be),
      .s_rd_gnt_i(s_rd_gnt), .s_rd_data_i(s_rd_data),
      .s_wr_req_o(s_wr_req), .s_wr_addr_o(s_wr_addr), .s_wr_data_o(s_wr_data),
      .s_wr_be_o(s_wr_be), .s_wr_gnt_i(s_wr_gnt),
      .o_owner(o_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { bit rd; logic [31:0] addr; logic [31:0] data; } txn_t;
   typedef struct { int idx; bit rd; logic [31:0] addr; logic [31:0] data; int cyc; } glog_t;

   txn_t        q0[$];
   txn_t        q1[$];
   glog_t       glog[$];
   logic [31:0] mem [logic [31:0]];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int stall = 0;
   int stall_max = 0;

   bit          rd_pend = 0;
   int          rd_pend_idx = 0;
   logic [31:0] rd_pend_val = 0;
   bit          rd_now = 0;
   int          rd_now_idx = 0;
   logic [31:0] rd_now_val = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic txn_t mk(input bit rd, input logic [31:0] addr, input logic [31:0] data);
      txn_t t;
      t.rd = rd; t.addr = addr; t.data = data;
      return t;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5a5a_0000;
   endfunction

   task automatic drive_masters();
      if (q0.size() > 0) begin
         m0_rd_req = q0[0].rd;  m0_wr_req = !q0[0].rd;
         m0_rd_addr = q0[0].addr; m0_wr_addr = q0[0].addr; m0_wr_data = q0[0].data;
      end else begin
         m0_rd_req = 1'b0; m0_wr_req = 1'b0;
      end
      if (q1.size() > 0) begin
         m1_rd_req = q1[0].rd;  m1_wr_req = !q1[0].rd;
         m1_rd_addr = q1[0].addr; m1_wr_addr = q1[0].addr; m1_wr_data = q1[0].data;
      end else begin
         m1_rd_req = 1'b0; m1_wr_req = 1'b0;
      end
   endtask

   // Observation point of a cycle: record grants, check routing and read return.
   task automatic observe();
      bit    g0, g1;
      int    k;
      txn_t  t;
      glog_t g;
      if (rd_now) begin
         check("rd_data_owner", rd_now_idx == 0 ? m0_rd_data : m1_rd_data, rd_now_val);
         check("rd_data_other", rd_now_idx == 0 ? m1_rd_data : m0_rd_data, 32'h0);
      end
      g0 = m0_rd_gnt | m0_wr_gnt;
      g1 = m1_rd_gnt | m1_wr_gnt;
      check("one_gnt", {31'b0, g0 & g1}, 32'h0);
      check("gnt_follow", {31'b0, g0 | g1}, {31'b0, s_rd_gnt | s_wr_gnt});
      if (g0 || g1) begin
         k = g0 ? 0 : 1;
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            check("gnt_no_req", k, 32'hffff_ffff);
         end else begin
            t = (k == 0) ? q0[0] : q1[0];
            check("gnt_owner", {30'b0, o_owner}, k == 0 ? 32'd1 : 32'd2);
            check("gnt_kind", {31'b0, k == 0 ? m0_rd_gnt : m1_rd_gnt}, {31'b0, t.rd});
            if (t.rd) begin
               check("rd_addr", s_rd_addr, t.addr);
               rd_pend = 1; rd_pend_idx = k; rd_pend_val = mem_rd(s_rd_addr);
            end else begin
               check("wr_addr", s_wr_addr, t.addr);
               check("wr_data", s_wr_data, t.data);
               mem[s_wr_addr] = s_wr_data;
            end
            g.idx = k; g.rd = t.rd; g.addr = t.addr; g.data = t.data; g.cyc = cyc;
            glog.push_back(g);
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            stall = $urandom_range(stall_max, 0);
         end
      end
   endtask

   // One clock cycle of master and slave behaviour; returns at posedge+3.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      drive_masters();
      rd_now = rd_pend; rd_now_idx = rd_pend_idx; rd_now_val = rd_pend_val;
      rd_pend = 0;
      if (rd_now) s_rd_data = rd_now_val;
      #1;
      s_rd_gnt = 1'b0;
      s_wr_gnt = 1'b0;
      if (s_rd_req || s_wr_req) begin
         if (stall == 0) begin
            if (s_rd_req) s_rd_gnt = 1'b1;
            else          s_wr_gnt = 1'b1;
         end else begin
            stall--;
         end
      end
      #1;
      observe();
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int b;
      b = 0;
      while (glog.size() < n && b < budget) begin
         tick();
         b++;
      end
      check(tag, glog.size(), n);
   endtask

   initial begin
      int          base;
      int          c0, c1, exp_idx;
      logic [31:0] a0[8], d0[8], a1[8], d1[8];
      logic [31:0] rdval;

      m0_rd_req = 0; m0_wr_req = 0; m0_rd_addr = 0; m0_wr_addr = 0; m0_wr_data = 0;
      m1_rd_req = 0; m1_wr_req = 0; m1_rd_addr = 0; m1_wr_addr = 0; m1_wr_data = 0;
      m0_rd_be = 4'hf; m0_wr_be = 4'hf; m1_rd_be = 4'hf; m1_wr_be = 4'hf;
      s_rd_gnt = 0; s_wr_gnt = 0; s_rd_data = 0;
      rst_n = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_owner", {30'b0, o_owner}, 32'h0);
      check("rst_s_rd_req", {31'b0, s_rd_req}, 32'h0);
      check("rst_s_wr_req", {31'b0, s_wr_req}, 32'h0);
      check("rst_gnts", {28'b0, m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt}, 32'h0);
      #2 rst_n = 1'b1;

      // Single read from m1
      mem[32'h100] = 32'h928cd0f1;
      q1.push_back(mk(1'b1, 32'h100, 32'h0));
      tick();
      check("t1_sreq_pre", {31'b0, s_rd_req}, 32'h0);
      tick();
      check("t1_sreq_rise", {31'b0, s_rd_req}, 32'h1);
      check("t1_gnt_coincide", {31'b0, m1_rd_gnt}, {31'b0, s_rd_gnt});
      check("t1_gnt", {31'b0, m1_rd_gnt}, 32'h1);
      tick();
      check("t1_m1_data", m1_rd_data, 32'h928cd0f1);
      check("t1_m0_data", m0_rd_data, 32'h0);
      tick();

      // Tie: m0 then m1, one IDLE cycle between
      q0.push_back(mk(1'b0, 32'h200, $urandom));
      q1.push_back(mk(1'b0, 32'h204, $urandom));
      base = glog.size();
      run_until(base + 2, 20, "t2_done");
      if (glog.size() >= base + 2) begin
         check("t2_first", glog[base].idx, 0);
         check("t2_first_addr", glog[base].addr, 32'h200);
         check("t2_second", glog[base+1].idx, 1);
         check("t2_gap", glog[base+1].cyc - glog[base].cyc, 2);
      end
      tick();

      // Sustained contention with random slave stalls
      stall_max = 3;
      for (int i = 0; i < 8; i++) begin
         a0[i] = 32'h1000 + i * 4; d0[i] = $urandom;
         a1[i] = 32'h2000 + i * 4; d1[i] = $urandom;
         q0.push_back(mk(1'b0, a0[i], d0[i]));
         q1.push_back(mk(1'b0, a1[i], d1[i]));
      end
      base = glog.size();
      run_until(base + 16, 400, "t3_done");
      if (glog.size() >= base + 16) begin
         c0 = 0; c1 = 0;
         for (int j = 0; j < 16; j++) begin
`ifdef NAIVE_ARB_FIXED_PRIO_EN
            exp_idx = (j < 8) ? 0 : 1;
`else
            exp_idx = j % 2;
`endif
            check("t3_order", glog[base+j].idx, exp_idx);
            if (glog[base+j].idx == 0) c0++; else c1++;
         end
         check("t3_cnt_m0", c0, 8);
         check("t3_cnt_m1", c1, 8);
      end
      for (int i = 0; i < 8; i++) begin
         check("t3_mem_m0", mem_rd(a0[i]), d0[i]);
         check("t3_mem_m1", mem_rd(a1[i]), d1[i]);
      end

      // Read-return routing across a following m1 ownership
      stall_max = 0; stall = 0;
      rdval = $urandom | 32'h1;
      mem[32'h300] = rdval;
      q0.push_back(mk(1'b1, 32'h300, 32'h0));
      base = glog.size();
      run_until(base + 1, 10, "t4_rd");
      tick();
      check("t4_m0_eq_s", m0_rd_data, s_rd_data);
      check("t4_m1_zero", m1_rd_data, 32'h0);
      q1.push_back(mk(1'b0, 32'h304, $urandom));
      tick();
      tick();
      tick();
      check("t4_m1_granted", glog.size(), base + 2);
      check("t4_hold_m0", m0_rd_data, rdval);
      check("t4_hold_m1", m1_rd_data, 32'h0);

      // Reset during a stalled OWN1; m0 completes first so last grant is m0
      q0.push_back(mk(1'b0, 32'h3f0, $urandom));
      base = glog.size();
      run_until(base + 1, 10, "t5_pre");
      tick();
      stall = 50;
      q1.push_back(mk(1'b0, 32'h400, $urandom));
      tick();
      tick();
      check("t5_own1", {30'b0, o_owner}, 32'h2);
      check("t5_sreq_on", {31'b0, s_wr_req}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_sreq_off", {31'b0, s_wr_req}, 32'h0);
      check("t5_srd_off", {31'b0, s_rd_req}, 32'h0);
      check("t5_owner_idle", {30'b0, o_owner}, 32'h0);
      check("t5_no_gnt", {31'b0, m1_wr_gnt | m0_wr_gnt}, 32'h0);
      q1.delete();
      m1_wr_req = 1'b0;
      stall = 0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      q0.push_back(mk(1'b0, 32'h500, $urandom));
      q1.push_back(mk(1'b0, 32'h504, $urandom));
      base = glog.size();
      run_until(base + 2, 20, "t5_done");
      if (glog.size() >= base + 2)
         check("t5_tie_m0", glog[base].idx, 0);
      tick();

      // Owner drops request before grant; last grant (m0) must survive
      q0.push_back(mk(1'b0, 32'h5f0, $urandom));
      base = glog.size();
      run_until(base + 1, 10, "t6_pre");
      tick();
      stall = 50;
      q1.push_back(mk(1'b1, 32'h600, 32'h0));
      tick();
      tick();
      check("t6_own1", {30'b0, o_owner}, 32'h2);
      check("t6_sreq_on", {31'b0, s_rd_req}, 32'h1);
      q1.delete();
      base = glog.size();
      tick();
      check("t6_sreq_drop", {31'b0, s_rd_req}, 32'h0);
      tick();
      check("t6_idle", {30'b0, o_owner}, 32'h0);
      check("t6_no_gnt", glog.size(), base);
      stall = 0;
      q0.push_back(mk(1'b0, 32'h610, $urandom));
      q1.push_back(mk(1'b0, 32'h614, $urandom));
      run_until(base + 2, 20, "t6_done");
`ifdef NAIVE_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = 1;
`endif
      if (glog.size() >= base + 2)
         check("t6_tie_after_drop", glog[base].idx, exp_idx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
